// File: rtl/csr_access_unit.sv
// Zicsr initiator towards the CSR register bank. A request is latched when it is
// accepted. The unit then reads the old CSR value, builds the read-modify-write
// value and issues a single-cycle write when one is needed. Finally it presents
// the old value for rd writeback on a valid/ready response port.
module csr_access_unit #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned CSR_AW = 12
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_funct3,
    input  logic [CSR_AW-1:0] req_addr,
    input  logic [4:0]        req_rs1_idx,
    input  logic [XLEN-1:0]   req_rs1_val,
    input  logic [4:0]        req_rd,
    input  logic              flush,
    output logic [CSR_AW-1:0] csr_raddr,
    input  logic [XLEN-1:0]   csr_rdata,
    output logic              csr_wen,
    output logic [CSR_AW-1:0] csr_waddr,
    output logic [XLEN-1:0]   csr_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_rdata,
    output logic [4:0]        resp_rd,
    output logic              resp_illegal
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        RESP
    } state_t;

    localparam logic [CSR_AW-1:0] ADDR_CYCLE    = CSR_AW'(12'hC00);
    localparam logic [CSR_AW-1:0] ADDR_CYCLEH   = CSR_AW'(12'hC80);
    localparam logic [CSR_AW-1:0] ADDR_INSTRET  = CSR_AW'(12'hC02);
    localparam logic [CSR_AW-1:0] ADDR_INSTRETH = CSR_AW'(12'hC82);

    state_t            state;
    state_t            next_state;
    logic [2:0]        funct3_q;
    logic [CSR_AW-1:0] addr_q;
    logic [4:0]        rd_q;
    logic [4:0]        rs1_idx_q;
    logic [XLEN-1:0]   rs1_val_q;
    logic [XLEN-1:0]   old_q;
    logic              illegal_q;

    logic              accept;
    logic              legal_funct3;
    logic              legal_addr;
    logic              legal_req;
    logic [XLEN-1:0]   src;
    logic [XLEN-1:0]   new_val;
    logic              do_write;

    assign accept       = req_valid && req_ready;
    assign legal_funct3 = (req_funct3 != 3'b000) && (req_funct3 != 3'b100);
    assign legal_addr   = (req_addr == ADDR_CYCLE)   || (req_addr == ADDR_CYCLEH) ||
                          (req_addr == ADDR_INSTRET) || (req_addr == ADDR_INSTRETH);
    assign legal_req    = legal_funct3 && legal_addr;

    // Immediate forms use the rs1 index field as a zero-extended 5-bit operand
    assign src      = funct3_q[2] ? XLEN'(rs1_idx_q) : rs1_val_q;
    // Set/clear with rs1 == x0 must not write; plain swaps always write
    assign do_write = (funct3_q[1:0] == 2'b01) || (rs1_idx_q != 5'd0);

    // Read-modify-write value from the captured old value
    always_comb begin
        new_val = src;
        case (funct3_q[1:0])
            2'b10:   new_val = old_q | src;
            2'b11:   new_val = old_q & ~src;
            default: new_val = src;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and all state-decoded outputs
    always_comb begin
        next_state   = state;
        req_ready    = 1'b0;
        csr_raddr    = '0;
        csr_wen      = 1'b0;
        csr_waddr    = '0;
        csr_wdata    = '0;
        resp_valid   = 1'b0;
        resp_rdata   = '0;
        resp_rd      = rd_q;
        resp_illegal = 1'b0;
        case (state)
            IDLE: begin
                req_ready = !flush;
                if (accept) begin
                    next_state = legal_req ? READ : RESP;
                end
            end
            READ: begin
                csr_raddr = addr_q;
                if (flush) begin
                    next_state = IDLE;
                end else if (do_write) begin
                    next_state = WRITE;
                end else begin
                    next_state = RESP;
                end
            end
            WRITE: begin
                // A flush here still lets this cycle's write land
                csr_wen    = 1'b1;
                csr_waddr  = addr_q;
                csr_wdata  = new_val;
                next_state = flush ? IDLE : RESP;
            end
            RESP: begin
                resp_valid   = 1'b1;
                resp_rdata   = old_q;
                resp_illegal = illegal_q;
                if (flush || resp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Request latch on accept and old-value capture at the end of READ
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            funct3_q  <= '0;
            addr_q    <= '0;
            rd_q      <= '0;
            rs1_idx_q <= '0;
            rs1_val_q <= '0;
            old_q     <= '0;
            illegal_q <= 1'b0;
        end else if (accept) begin
            funct3_q  <= req_funct3;
            addr_q    <= req_addr;
            rd_q      <= req_rd;
            rs1_idx_q <= req_rs1_idx;
            rs1_val_q <= req_rs1_val;
            old_q     <= '0;
            illegal_q <= !legal_req;
        end else if (state == READ) begin
            old_q <= csr_rdata;
        end
    end

endmodule

// File: doc/csr_access_unit.md
Name: csr_access_unit

Overview:
- Initiator side of the CSR register bank port: executes Zicsr instructions (CSRRW/CSRRS/CSRRC and immediate forms) from the execute stage.
- Sequences bank read address, captures old value, computes read-modify-write value, issues single-cycle write, returns old value for rd writeback.
- Sits between execute stage (valid/ready request) and CSR register bank (raddr/rdata, wen/waddr/wdata).

Parameters:
- XLEN, 32, data width of CSR values and rs1 operand
- CSR_AW, 12, CSR address width

Ports:
- clk  in  1  clock, rising edge
- nrst  in  1  reset, asynchronous, active-low
- req_valid  in  1  CSR instruction presented
- req_ready  out  1  unit can accept (high only in IDLE)
- req_funct3  in  3  001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
- req_addr  in  CSR_AW  CSR address (inst[31:20])
- req_rs1_idx  in  5  rs1 index; zimm for immediate forms
- req_rs1_val  in  XLEN  rs1 register value
- req_rd  in  5  destination register index
- flush  in  1  pipeline flush, abort current op
- csr_raddr  out  CSR_AW  bank read address
- csr_rdata  in  XLEN  bank read data (combinational from csr_raddr)
- csr_wen  out  1  bank write enable
- csr_waddr  out  CSR_AW  bank write address
- csr_wdata  out  XLEN  bank write data
- resp_valid  out  1  result available
- resp_ready  in  1  writeback accepts result
- resp_rdata  out  XLEN  old CSR value for rd
- resp_rd  out  5  latched req_rd
- resp_illegal  out  1  illegal CSR instruction

Behaviour:
- Reset (nrst low, async): state IDLE; req_ready=1; resp_valid=0, csr_wen=0; csr_raddr, csr_waddr, csr_wdata, resp_rdata, resp_rd, resp_illegal all 0.
- States IDLE, READ, WRITE, RESP. Accept on req_valid&&req_ready rising edge: latch funct3, addr, rd, rs1_idx, rs1_val.
- Legal: funct3 not in {000,100} and addr in {CYCLE 0xC00, CYCLEH 0xC80, INSTRET 0xC02, INSTRETH 0xC82}. Illegal: IDLE->RESP, resp_rdata=0, resp_illegal=1, no bank access.
- Legal: IDLE->READ. READ: csr_raddr=latched addr; old=csr_rdata captured at end of cycle.
- Operand src = funct3[2] ? zero-extended 5-bit zimm : rs1_val. RW: new=src; RS: new=old|src; RC: new=old&~src.
- Write suppressed for RS/RC/RSI/RCI when rs1_idx==0; RW/RWI always write (even rd==0). Read always performed (bank reads side-effect free).
- READ->WRITE if write, else READ->RESP. WRITE: csr_wen=1 exactly one cycle, csr_waddr=addr, csr_wdata=new; ->RESP.
- RESP: resp_valid=1, resp_rdata=old, resp_rd, resp_illegal=0; hold stable until resp_valid&&resp_ready, then IDLE.
- csr_wen=0 in all states except WRITE; csr_raddr=0 outside READ.
- Latency from accept edge T: resp_valid at T+2 (no write) or T+3 (write); illegal at T+1. Back-to-back: next accept earliest cycle after response handshake.
- flush in IDLE/READ/RESP: next state IDLE, no write, response dropped. flush during WRITE: write still completes that cycle, then IDLE, no response. flush with req_valid in IDLE: request not accepted (req_ready forced 0 while flush).
- Reset mid-op: immediate return to IDLE, csr_wen deasserted asynchronously.

Test Plan:
- Reset then CSRRS x5, 0xC00, rs1=x0, bank cycle=0x10 at READ -> no csr_wen pulse, resp_valid at T+2, resp_rdata=0x10, resp_rd=5.
- CSRRW 0xC02, rs1_val=0xDEADBEEF, old=0x7 -> csr_wen one cycle at T+2, waddr=0xC02, wdata=0xDEADBEEF; resp_rdata=0x7 at T+3.
- CSRRCI 0xC80, zimm=0x1F, old=0xFFFF00FF -> wdata=0xFFFF00E0; CSRRSI zimm=0x3, old=0x10 -> wdata=0x13.
- funct3=100 or addr=0x300 -> resp_illegal=1 at T+1, resp_rdata=0, csr_wen never asserted.
- resp_ready held low 5 cycles -> resp_valid, resp_rdata, resp_rd stable, req_ready=0; accept next request cycle after handshake.
- flush in READ -> no write, no resp, IDLE next cycle; flush in WRITE -> write occurs, no resp; nrst pulse in WRITE -> csr_wen drops immediately, all outputs at reset values.
